sym_packer: RTL and testbench
=============================

SYM_PACKER -- requirements
Module: sym_packer

Interface
REQ-001 Parameter: DEPTH, default 2, number of packed words the output FIFO holds (power of two, >= 2).
REQ-002 clk  input  1  single clock, all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  in_sym carries a symbol this cycle.
REQ-005 in_sym  input  2  2-bit symbol from the upstream swap register output.
REQ-006 in_ready  output  1  block accepts a symbol this cycle.
REQ-007 flush  input  1  one-cycle request to emit the current partial word.
REQ-008 out_valid  output  1  FIFO head valid.
REQ-009 out_data  output  8  packed word.
REQ-010 out_len  output  3  valid symbols in out_data, 1..4.
REQ-011 out_ready  input  1  downstream accepts the head word.

Function
REQ-012 Symbol accepted when in_valid && in_ready; the first symbol of a word goes to bits [7:6], then [5:4], [3:2], [1:0].
REQ-013 Assembly register holds 0..3 symbols; sym_cnt counts them.
REQ-014 4th accepted symbol completes the word; {asm, in_sym} is pushed to the FIFO with out_len=4 on the same edge; sym_cnt returns to 0.
REQ-015 Word appears on out_valid one cycle after the completing edge (push latency 1).
REQ-016 in_ready = !(fifo_full && sym_cnt==3) || state==FLUSH_PEND ? 0 : 1. It is registered-state based only, with no combinational path from out_ready.
REQ-017 Pop when out_valid && out_ready; simultaneous push and pop while full is not allowed (in_ready already low); push and pop while not full both take effect.
REQ-018 FSM states: ASSEMBLE, FLUSH_PEND.
REQ-019 ASSEMBLE + flush, FIFO not full: the partial word is pushed, zero-padded in the unused low bits, with out_len=sym_cnt (including any symbol accepted the same cycle); the state stays ASSEMBLE.
REQ-020 ASSEMBLE + flush, FIFO full: the state goes to FLUSH_PEND; in_ready=0.
REQ-021 FLUSH_PEND: the partial word is pushed on the first cycle the FIFO is not full, then the state returns to ASSEMBLE.
REQ-022 Flush with sym_cnt==0 and no symbol accepted that cycle: ignored, no push.
REQ-023 Flush on the same cycle as a 4th symbol: the full word is pushed with out_len=4; the flush is consumed.
REQ-024 out_data and out_len are undefined-free: they hold the FIFO head, or zero when empty.

Reset
REQ-025 Reset clears sym_cnt, the assembly register and the FIFO pointers, and sets state=ASSEMBLE.
REQ-026 In the cycle after reset: out_valid=0, out_data=0, out_len=0, in_ready=1.
REQ-027 Reset mid-word or in FLUSH_PEND discards all buffered symbols and words, and produces no output.

Configuration
REQ-028 Macro SYM_PACKER_PARITY_EN defined: output out_par (1 bit) = even parity of out_data is added; it is stored per FIFO entry, and is 0 on reset/empty.
REQ-029 Macro SYM_PACKER_PARITY_EN undefined: port out_par and its storage are absent; all other behaviour is identical.

Structure
REQ-030 Package sym_packer_pkg holds SYM_W=2, WORD_W=8, SYMS_PER_WORD=4, LEN_W=3, and the state enum {ASSEMBLE, FLUSH_PEND}.
REQ-031 Sub-module sym_packer_fifo is a synchronous FIFO of DEPTH x (WORD_W+LEN_W[+1]) with full/empty flags; the assembly logic and FSM stay in sym_packer.

Verification
REQ-032 Reset, then in_sym 3,2,1,0 on consecutive cycles with out_ready=1 -> one word out_data=8'hE4, out_len=4, out_valid one cycle after the 4th symbol.
REQ-033 Symbols 1,1 then flush -> out_data=8'h50, out_len=2; a following flush with no symbols -> no word.
REQ-034 out_ready=0, 3 full words sent (DEPTH=2) -> in_ready drops when sym_cnt==3 and the FIFO is full; after one pop, the 4th symbol is accepted; no word is lost or duplicated.
REQ-035 FIFO full, sym_cnt=2, flush -> FLUSH_PEND, in_ready=0; out_ready pulsed -> partial word pushed next, state returns to ASSEMBLE.
REQ-036 Reset asserted with sym_cnt=3 and 2 words queued -> next cycle out_valid=0, in_ready=1; a fresh 0,0,0,3 yields 8'h03.
REQ-037 With SYM_PACKER_PARITY_EN defined: word 8'hE4 -> out_par=0; word 8'h01 -> out_par=1.

Source files
------------

// File: rtl/sym_packer_pkg.sv
// rtl/sym_packer_pkg.sv - shared widths, FSM state type and symbol placement helper for sym_packer
//
// Purpose: constants and types shared by sym_packer and sym_packer_fifo.
//    SYM_W          width of one input symbol
//    WORD_W         width of one packed output word
//    SYMS_PER_WORD  symbols per full word
//    LEN_W          width of the symbol-count field stored with each word
//    state_e        packer FSM states
//    place_sym()    drops a symbol into its slot of a left-aligned word
package sym_packer_pkg;

   localparam int SYM_W         = 2;
   localparam int WORD_W        = 8;
   localparam int SYMS_PER_WORD = 4;
   localparam int LEN_W         = 3;
   localparam int CNT_W         = 2;

   typedef enum logic {
      ASSEMBLE   = 1'b0,
      FLUSH_PEND = 1'b1
   } state_e;

   // Slot 0 is the most significant symbol; unused low slots stay as they were (zero after clear).
   function automatic logic [WORD_W-1:0] place_sym(input logic [WORD_W-1:0] word,
                                                   input logic [SYM_W-1:0]  sym,
                                                   input logic [CNT_W-1:0]  slot);
      logic [WORD_W-1:0] r;
      r = word;
      case (slot)
         2'd0:    r[7:6] = sym;
         2'd1:    r[5:4] = sym;
         2'd2:    r[3:2] = sym;
         default: r[1:0] = sym;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/sym_packer_fifo.sv
// rtl/sym_packer_fifo.sv - synchronous FIFO holding packed words for sym_packer
//
// Purpose: DEPTH x WIDTH synchronous FIFO with full/empty flags; head reads as zero when empty.
// Ports:
//    clk        clock, rising edge
//    reset      synchronous active-high reset, clears pointers
//    push       write push_data (ignored when full)
//    push_data  entry to write
//    pop        drop head entry (ignored when empty)
//    head_data  current head entry, zero when empty
//    full       no free entry
//    empty      no stored entry
module sym_packer_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 11
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   // One extra pointer bit tells full from empty when the index bits match.
   logic [AW:0]      wr_ptr_q;
   logic [AW:0]      rd_ptr_q;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   assign head_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push && !full) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
            wr_ptr_q                <= wr_ptr_q + (AW+1)'(1);
         end
         if (pop && !empty) begin
            rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
         end
      end
   end

endmodule

// File: rtl/sym_packer.sv
// rtl/sym_packer.sv - packs 2-bit symbols into 8-bit words with flush and an output FIFO
//
// Purpose: accumulates four 2-bit symbols MSB-first into a byte, queues complete or flushed
//    partial words (with their symbol count) in a DEPTH-entry FIFO.
// Optional feature: define SYM_PACKER_PARITY_EN to add out_par (even parity of out_data,
//    stored per FIFO entry).
// Ports:
//    clk        clock, rising edge
//    reset      synchronous active-high reset
//    in_valid   in_sym carries a symbol
//    in_sym     2-bit symbol
//    in_ready   symbol accepted this cycle (depends on registered state only)
//    flush      request to emit the current partial word
//    out_valid  FIFO head valid
//    out_data   packed word at FIFO head, zero when empty
//    out_len    valid symbols in out_data (1..4), zero when empty
//    out_par    even parity of out_data (SYM_PACKER_PARITY_EN only)
//    out_ready  downstream accepts the head word
module sym_packer
   import sym_packer_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [1:0]       in_sym,
   output logic             in_ready,
   input  logic             flush,
   output logic             out_valid,
   output logic [7:0]       out_data,
   output logic [2:0]       out_len,
`ifdef SYM_PACKER_PARITY_EN
   output logic             out_par,
`endif
   input  logic             out_ready
);

`ifdef SYM_PACKER_PARITY_EN
   localparam int FIFO_W = WORD_W + LEN_W + 1;
`else
   localparam int FIFO_W = WORD_W + LEN_W;
`endif

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    sym_cnt_q, sym_cnt_d;
   logic [WORD_W-1:0]   asm_q, asm_d;

   logic                fifo_full, fifo_empty;
   logic [FIFO_W-1:0]   fifo_head;
   logic [FIFO_W-1:0]   fifo_wdata;

   logic                push;
   logic [WORD_W-1:0]   push_word;
   logic [LEN_W-1:0]    push_len;

   logic                accept;
   logic [WORD_W-1:0]   asm_in;
   logic [LEN_W-1:0]    eff_len;

   // Blocking only on a full FIFO with a word about to complete keeps in_ready free of out_ready.
   assign in_ready = !((fifo_full && (sym_cnt_q == CNT_W'(SYMS_PER_WORD - 1))) ||
                       (state_q == FLUSH_PEND));
   assign accept   = in_valid && in_ready;

   // Assembly view including a symbol accepted this cycle, so flush sees it too.
   assign asm_in  = accept ? place_sym(asm_q, in_sym, sym_cnt_q) : asm_q;
   assign eff_len = {1'b0, sym_cnt_q} + {2'b00, accept};

   always_comb begin
      state_d   = state_q;
      sym_cnt_d = sym_cnt_q;
      asm_d     = asm_q;
      push      = 1'b0;
      push_word = '0;
      push_len  = '0;

      case (state_q)
         ASSEMBLE: begin
            if (accept && (sym_cnt_q == CNT_W'(SYMS_PER_WORD - 1))) begin
               // Completing symbol wins over a coincident flush; the flush is absorbed.
               push      = 1'b1;
               push_word = asm_in;
               push_len  = LEN_W'(SYMS_PER_WORD);
               sym_cnt_d = '0;
               asm_d     = '0;
            end else if (flush && (eff_len != '0)) begin
               if (!fifo_full) begin
                  push      = 1'b1;
                  push_word = asm_in;
                  push_len  = eff_len;
                  sym_cnt_d = '0;
                  asm_d     = '0;
               end else begin
                  // Park the partial word (with any symbol taken now) until space frees up.
                  state_d   = FLUSH_PEND;
                  asm_d     = asm_in;
                  sym_cnt_d = eff_len[CNT_W-1:0];
               end
            end else if (accept) begin
               asm_d     = asm_in;
               sym_cnt_d = sym_cnt_q + CNT_W'(1);
            end
         end

         FLUSH_PEND: begin
            if (!fifo_full) begin
               push      = 1'b1;
               push_word = asm_q;
               push_len  = {1'b0, sym_cnt_q};
               sym_cnt_d = '0;
               asm_d     = '0;
               state_d   = ASSEMBLE;
            end
         end

         default: begin
            state_d = ASSEMBLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ASSEMBLE;
         sym_cnt_q <= '0;
         asm_q     <= '0;
      end else begin
         state_q   <= state_d;
         sym_cnt_q <= sym_cnt_d;
         asm_q     <= asm_d;
      end
   end

`ifdef SYM_PACKER_PARITY_EN
   assign fifo_wdata = {^push_word, push_len, push_word};
   assign out_par    = fifo_head[WORD_W+LEN_W];
`else
   assign fifo_wdata = {push_len, push_word};
`endif

   sym_packer_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (FIFO_W)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (fifo_wdata),
      .pop       (out_ready),
      .head_data (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign out_valid = !fifo_empty;
   assign out_data  = fifo_head[WORD_W-1:0];
   assign out_len   = fifo_head[WORD_W +: LEN_W];

endmodule

// File: tb/tb_sym_packer.sv
// tb/tb_sym_packer.sv - directed self-checking bench for sym_packer
module tb_sym_packer;

   logic       clk;
   logic       reset;
   logic       in_valid;
   logic [1:0] in_sym;
   logic       in_ready;
   logic       flush;
   logic       out_valid;
   logic [7:0] out_data;
   logic [2:0] out_len;
   logic       out_ready;
`ifdef SYM_PACKER_PARITY_EN
   logic       out_par;
`endif

   int n_tests;
   int n_fail;

   sym_packer #(.DEPTH(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_sym    (in_sym),
      .in_ready  (in_ready),
      .flush     (flush),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_len   (out_len),
`ifdef SYM_PACKER_PARITY_EN
      .out_par   (out_par),
`endif
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_sym(input logic [1:0] s);
      in_valid = 1'b1;
      in_sym   = s;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
      n_tests++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL rst_data: got %h expected 00", out_data); end
      n_tests++; if (out_len !== 3'd0) begin n_fail++; $display("FAIL rst_len: got %0d expected 0", out_len); end
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
      reset = 1'b0;
   endtask

   task automatic test_full_word();
      out_ready = 1'b1;
      send_sym(2'd3);
      send_sym(2'd2);
      send_sym(2'd1);
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fw_early_valid: got %b expected 0", out_valid); end
      send_sym(2'd0);
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL fw_valid: got %b expected 1", out_valid); end
      n_tests++; if (out_data !== 8'hE4) begin n_fail++; $display("FAIL fw_data: got %h expected e4", out_data); end
      n_tests++; if (out_len !== 3'd4) begin n_fail++; $display("FAIL fw_len: got %0d expected 4", out_len); end
      tick();
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fw_popped: got %b expected 0", out_valid); end
   endtask

   task automatic test_flush();
      out_ready = 1'b1;
      send_sym(2'd1);
      send_sym(2'd1);
      flush = 1'b1; tick(); flush = 1'b0;
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL fl_valid: got %b expected 1", out_valid); end
      n_tests++; if (out_data !== 8'h50) begin n_fail++; $display("FAIL fl_data: got %h expected 50", out_data); end
      n_tests++; if (out_len !== 3'd2) begin n_fail++; $display("FAIL fl_len: got %0d expected 2", out_len); end
      tick();
      flush = 1'b1; tick(); flush = 1'b0;
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fl_empty_flush: got %b expected 0", out_valid); end
      tick();
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fl_empty_flush2: got %b expected 0", out_valid); end
      // flush together with a 2nd symbol counts that symbol
      send_sym(2'd2);
      in_valid = 1'b1; in_sym = 2'd3; flush = 1'b1;
      tick();
      in_valid = 1'b0; flush = 1'b0;
      n_tests++; if (out_data !== 8'hB0) begin n_fail++; $display("FAIL fl_same_data: got %h expected b0", out_data); end
      n_tests++; if (out_len !== 3'd2) begin n_fail++; $display("FAIL fl_same_len: got %0d expected 2", out_len); end
      tick();
      // flush together with the 4th symbol: one full word only
      send_sym(2'd0);
      send_sym(2'd1);
      send_sym(2'd2);
      in_valid = 1'b1; in_sym = 2'd3; flush = 1'b1;
      tick();
      in_valid = 1'b0; flush = 1'b0;
      n_tests++; if (out_data !== 8'h1B) begin n_fail++; $display("FAIL fl_4th_data: got %h expected 1b", out_data); end
      n_tests++; if (out_len !== 3'd4) begin n_fail++; $display("FAIL fl_4th_len: got %0d expected 4", out_len); end
      tick();
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fl_4th_extra: got %b expected 0", out_valid); end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      send_sym(2'd0); send_sym(2'd1); send_sym(2'd2); send_sym(2'd3);
      send_sym(2'd3); send_sym(2'd3); send_sym(2'd3); send_sym(2'd3);
      send_sym(2'd2); send_sym(2'd2); send_sym(2'd2);
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_low: got %b expected 0", in_ready); end
      n_tests++; if (out_data !== 8'h1B) begin n_fail++; $display("FAIL bp_head1: got %h expected 1b", out_data); end
      in_valid = 1'b1; in_sym = 2'd1;
      tick();
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_still_low: got %b expected 0", in_ready); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready_back: got %b expected 1", in_ready); end
      n_tests++; if (out_data !== 8'hFF) begin n_fail++; $display("FAIL bp_head2: got %h expected ff", out_data); end
      tick();
      in_valid = 1'b0;
      out_ready = 1'b1;
      n_tests++; if (out_data !== 8'hFF) begin n_fail++; $display("FAIL bp_drain1: got %h expected ff", out_data); end
      tick();
      n_tests++; if (out_data !== 8'hA9) begin n_fail++; $display("FAIL bp_drain2_data: got %h expected a9", out_data); end
      n_tests++; if (out_len !== 3'd4) begin n_fail++; $display("FAIL bp_drain2_len: got %0d expected 4", out_len); end
      tick();
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got %b expected 0", out_valid); end
   endtask

   task automatic test_flush_pend();
      out_ready = 1'b0;
      send_sym(2'd0); send_sym(2'd0); send_sym(2'd0); send_sym(2'd1);
      send_sym(2'd0); send_sym(2'd0); send_sym(2'd0); send_sym(2'd2);
      send_sym(2'd3); send_sym(2'd1);
      flush = 1'b1; tick(); flush = 1'b0;
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fp_in_ready: got %b expected 0", in_ready); end
      tick();
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fp_hold: got %b expected 0", in_ready); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fp_after_pop: got %b expected 0", in_ready); end
      n_tests++; if (out_data !== 8'h02) begin n_fail++; $display("FAIL fp_head: got %h expected 02", out_data); end
      tick();
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fp_back_assemble: got %b expected 1", in_ready); end
      out_ready = 1'b1;
      tick();
      n_tests++; if (out_data !== 8'hD0) begin n_fail++; $display("FAIL fp_part_data: got %h expected d0", out_data); end
      n_tests++; if (out_len !== 3'd2) begin n_fail++; $display("FAIL fp_part_len: got %0d expected 2", out_len); end
      tick();
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fp_drained: got %b expected 0", out_valid); end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      send_sym(2'd0); send_sym(2'd0); send_sym(2'd0); send_sym(2'd1);
      send_sym(2'd0); send_sym(2'd0); send_sym(2'd0); send_sym(2'd2);
      send_sym(2'd1); send_sym(2'd2); send_sym(2'd3);
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rm_pre_ready: got %b expected 0", in_ready); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_valid: got %b expected 0", out_valid); end
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rm_in_ready: got %b expected 1", in_ready); end
      n_tests++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL rm_data: got %h expected 00", out_data); end
      out_ready = 1'b1;
      send_sym(2'd0); send_sym(2'd0); send_sym(2'd0); send_sym(2'd3);
      n_tests++; if (out_data !== 8'h03) begin n_fail++; $display("FAIL rm_fresh_data: got %h expected 03", out_data); end
      n_tests++; if (out_len !== 3'd4) begin n_fail++; $display("FAIL rm_fresh_len: got %0d expected 4", out_len); end
      tick();
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_no_stale: got %b expected 0", out_valid); end
   endtask

`ifdef SYM_PACKER_PARITY_EN
   task automatic test_parity();
      out_ready = 1'b1;
      send_sym(2'd3); send_sym(2'd2); send_sym(2'd1); send_sym(2'd0);
      n_tests++; if (out_par !== 1'b0) begin n_fail++; $display("FAIL par_e4: got %b expected 0", out_par); end
      tick();
      n_tests++; if (out_par !== 1'b0) begin n_fail++; $display("FAIL par_empty: got %b expected 0", out_par); end
      send_sym(2'd0); send_sym(2'd0); send_sym(2'd0); send_sym(2'd1);
      n_tests++; if (out_par !== 1'b1) begin n_fail++; $display("FAIL par_01: got %b expected 1", out_par); end
      tick();
   endtask
`endif

   initial begin
      clk       = 1'b0;
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_sym    = 2'd0;
      flush     = 1'b0;
      out_ready = 1'b0;
      n_tests   = 0;
      n_fail    = 0;

      test_reset();
      test_full_word();
      test_flush();
      test_backpressure();
      test_flush_pend();
      test_reset_mid();
`ifdef SYM_PACKER_PARITY_EN
      test_parity();
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
